mole_round_ctrl: RTL and testbench

- Game-round controller for the whack-a-mole design.
- Sits directly downstream of the pseudo-random mole generator and consumes its 5-bit one-hot mole position.
- Samples a position per round, lights it for a timed window, and judges debounced button presses as hit, wrong or timeout.
- Keeps score and lives, and drives the LEDs plus the game-over status to the display logic.

---
 rtl/mole_pkg.sv | 21 ++
 rtl/mole_btn_edge.sv | 21 ++
 rtl/mole_round_ctrl.sv | 131 +++++++++++++
 tb/tb_mole_round_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round controller.
package mole_pkg;

    localparam int MOLE_W = 5;
    localparam logic [MOLE_W-1:0] DEFAULT_MOLE = 5'b00001;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHOW,
        HIT,
        MISS,
        PAUSE,
        OVER
    } state_t;

    function automatic logic is_one_hot(input logic [MOLE_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/mole_btn_edge.sv
// Rising-edge detector for the debounced hole buttons.
module mole_btn_edge
    import mole_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [MOLE_W-1:0] btn,
    output logic [MOLE_W-1:0] rise
);

    logic [MOLE_W-1:0] r_btn_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_btn_prev <= '0;
        else       r_btn_prev <= btn;
    end

    assign rise = btn & ~r_btn_prev;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: lights a mole, judges presses, keeps score and lives.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int WINDOW_TICKS = 50,
    parameter int PAUSE_TICKS  = 10,
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic [MOLE_W-1:0]  mole_in,
    input  logic [MOLE_W-1:0]  btn,
    output logic [MOLE_W-1:0]  led,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               playing,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam int CNT_MAX = (WINDOW_TICKS > PAUSE_TICKS) ? WINDOW_TICKS : PAUSE_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_tick_cnt, w_tick_cnt_nxt;
    logic [MOLE_W-1:0]  r_target, w_target_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic [MOLE_W-1:0]  w_rise;
    logic [MOLE_W-1:0]  r_led;
    logic               r_playing, r_hit_pulse, r_miss_pulse, r_game_over;

    mole_btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .rise  (w_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_target_nxt   = r_target;
        w_score_nxt    = r_score;
        w_lives_nxt    = r_lives;
        unique case (r_state)
            IDLE, OVER: begin
                if (start) begin
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES_W'(LIVES);
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                w_target_nxt   = is_one_hot(mole_in) ? mole_in : DEFAULT_MOLE;
                w_tick_cnt_nxt = '0;
                w_state_nxt    = SHOW;
            end
            SHOW: begin
                // A press in the same cycle as the final tick still counts as a press.
                if (w_rise != '0) begin
                    w_state_nxt = (w_rise == r_target) ? HIT : MISS;
                end else if (tick) begin
                    if (r_tick_cnt == CNT_W'(WINDOW_TICKS - 1)) w_state_nxt = MISS;
                    else                                          w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end
            HIT: begin
                if (r_score != {SCORE_W{1'b1}}) w_score_nxt = r_score + 1'b1;
                w_tick_cnt_nxt = '0;
                w_state_nxt    = PAUSE;
            end
            MISS: begin
                if (r_lives != '0) w_lives_nxt = r_lives - 1'b1;
                w_tick_cnt_nxt = '0;
                w_state_nxt    = (r_lives <= LIVES_W'(1)) ? OVER : PAUSE;
            end
            PAUSE: begin
                if (tick) begin
                    if (r_tick_cnt == CNT_W'(PAUSE_TICKS - 1)) w_state_nxt = ARM;
                    else                                         w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_target     <= '0;
            r_score      <= '0;
            r_lives      <= LIVES_W'(LIVES);
            r_led        <= '0;
            r_playing    <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_target     <= w_target_nxt;
            r_score      <= w_score_nxt;
            r_lives      <= w_lives_nxt;
            r_led        <= (r_state == SHOW) ? r_target : '0;
            r_playing    <= r_state inside {ARM, SHOW, HIT, MISS, PAUSE};
            r_hit_pulse  <= (r_state == HIT);
            r_miss_pulse <= (r_state == MISS);
            r_game_over  <= (r_state == OVER);
        end
    end

    assign led        = r_led;
    assign score      = r_score;
    assign lives      = r_lives;
    assign playing    = r_playing;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed scoreboard bench for mole_round_ctrl; a second instance with SCORE_W=2 checks saturation.
module tb_mole_round_ctrl;
    import mole_pkg::*;

    typedef struct {
        logic is_hit;
        int   score;
        int   lives;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] mole_in = 5'b00100;
    logic [4:0] btn = 5'b00000;

    logic [4:0] led, led2;
    logic [7:0] score;
    logic [1:0] score2;
    logic [1:0] lives, lives2;
    logic       playing, playing2, hit_pulse, hit_pulse2;
    logic       miss_pulse, miss_pulse2, game_over, game_over2;

    exp_t q[$];
    int   m_score = 0;
    int   m_lives = 3;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    mole_round_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .mole_in(mole_in), .btn(btn),
        .led(led), .score(score), .lives(lives), .playing(playing),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
    );

    mole_round_ctrl #(.SCORE_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .mole_in(mole_in), .btn(btn),
        .led(led2), .score(score2), .lives(lives2), .playing(playing2),
        .hit_pulse(hit_pulse2), .miss_pulse(miss_pulse2), .game_over(game_over2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic push_exp(input logic is_hit);
        exp_t e;
        if (is_hit) m_score++;
        else        m_lives--;
        e.is_hit = is_hit;
        e.score  = m_score;
        e.lives  = m_lives;
        q.push_back(e);
    endtask

    // Steps until the led lights (bounded); optionally checks the cycles taken.
    task automatic wait_led(input string tag, input logic [4:0] exp, input int exp_lat);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            if (led != 5'b0) break;
            cyc();
            n++;
        end
        check(tag, led, exp);
        if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
    endtask

    // Waits for the next pulse, pops the scoreboard and compares kind, score and lives.
    task automatic expect_pulse(input string tag);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n++;
            if (hit_pulse || miss_pulse) break;
        end
        check({tag, "_seen"}, hit_pulse | miss_pulse, 1);
        check({tag, "_lat"}, n, 1);
        check({tag, "_sb"}, q.size() != 0, 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check({tag, "_hit"}, hit_pulse, e.is_hit);
            check({tag, "_miss"}, miss_pulse, !e.is_hit);
            check({tag, "_score"}, score, e.score);
            check({tag, "_lives"}, lives, e.lives);
            check({tag, "_score2"}, score2, (e.score > 3) ? 3 : e.score);
        end
        cyc();
        check({tag, "_once"}, {hit_pulse, miss_pulse}, 0);
    endtask

    task automatic press(input logic [4:0] mask);
        btn = mask;
        cyc();
        btn = 5'b0;
    endtask

    // Ten dark ticks; led must stay off and no pulse may appear.
    task automatic pause_ticks(input string tag);
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            if (led != 5'b0 || hit_pulse || miss_pulse) bad++;
        end
        check({tag, "_dark"}, bad, 0);
    endtask

    initial begin
        // Reset values
        cyc();
        cyc();
        check("rst_led", led, 0);
        check("rst_score", score, 0);
        check("rst_lives", lives, 3);
        check("rst_flags", {playing, hit_pulse, miss_pulse, game_over}, 0);
        reset = 1'b0;
        cyc();

        // Game 1: hit on target 00100
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_score", score, 0);
        check("start_lives", lives, 3);
        wait_led("g1r1_led", 5'b00100, 2);
        check("g1_playing", playing, 1);
        push_exp(1'b1);
        press(5'b00100);
        expect_pulse("g1r1");
        pause_ticks("g1r1");

        // Wrong button, then a press during PAUSE is ignored
        wait_led("g1r2_led", 5'b00100, 2);
        push_exp(1'b0);
        press(5'b00001);
        expect_pulse("g1r2");
        begin
            int pulses = 0;
            btn = 5'b00100;
            for (int i = 0; i < 4; i++) begin
                cyc();
                if (hit_pulse || miss_pulse) pulses++;
            end
            btn = 5'b0;
            cyc();
            check("pause_press_ignored", pulses, 0);
        end
        pause_ticks("g1r2");

        // Timeout on the 50th tick
        wait_led("g1r3_led", 5'b00100, 2);
        begin
            int pulses = 0;
            for (int i = 0; i < 49; i++) begin
                do_tick();
                if (hit_pulse || miss_pulse) pulses++;
            end
            check("timeout_early", pulses, 0);
            check("timeout_led_held", led, 5'b00100);
        end
        push_exp(1'b0);
        do_tick();
        expect_pulse("g1_timeout");
        pause_ticks("g1r3");

        // Correct rise on the final tick wins over timeout
        wait_led("g1r4_led", 5'b00100, 2);
        for (int i = 0; i < 49; i++) do_tick();
        push_exp(1'b1);
        btn  = 5'b00100;
        tick = 1'b1;
        cyc();
        btn  = 5'b0;
        tick = 1'b0;
        expect_pulse("g1_rise_vs_tick");
        pause_ticks("g1r4");

        // Last life lost -> OVER, score frozen
        wait_led("g1r5_led", 5'b00100, 2);
        push_exp(1'b0);
        press(5'b00010);
        expect_pulse("g1_last");
        check("over_flag", game_over, 1);
        check("over_playing", playing, 0);
        check("over_led", led, 0);
        check("over_lives", lives, 0);
        btn = 5'b00100;
        do_tick();
        do_tick();
        btn = 5'b0;
        cyc();
        check("over_score_frozen", score, 2);
        check("over_still", game_over, 1);

        // Restart from OVER with a zero mole position
        mole_in = 5'b00000;
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_score = 0;
        m_lives = 3;
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        cyc();
        check("restart_go", game_over, 0);
        check("restart_playing", playing, 1);
        wait_led("g2r1_led", 5'b00001, 1);
        push_exp(1'b1);
        press(5'b00001);
        expect_pulse("g2r1");
        mole_in = 5'b00101;
        pause_ticks("g2r1");

        wait_led("g2r2_led", 5'b00001, 2);
        push_exp(1'b1);
        press(5'b00001);
        expect_pulse("g2r2");

        // Button held from PAUSE through ARM into SHOW
        mole_in = 5'b00010;
        btn = 5'b00010;
        pause_ticks("g2r2");
        wait_led("g2r3_led", 5'b00010, 2);
        begin
            int pulses = 0;
            for (int i = 0; i < 5; i++) begin
                cyc();
                if (hit_pulse || miss_pulse) pulses++;
            end
            check("held_no_hit", pulses, 0);
        end
        btn = 5'b0;
        cyc();
        push_exp(1'b1);
        press(5'b00010);
        expect_pulse("g2r3");
        mole_in = 5'b00100;
        pause_ticks("g2r3");

        wait_led("g2r4_led", 5'b00100, 2);
        push_exp(1'b1);
        press(5'b00100);
        expect_pulse("g2r4");
        check("sat_score", score, 4);
        check("sat_score2", score2, 3);
        pause_ticks("g2r4");

        // Three consecutive misses, including a multi-bit press
        wait_led("g2r5_led", 5'b00100, 2);
        push_exp(1'b0);
        press(5'b00110);
        expect_pulse("g2_miss1");
        pause_ticks("g2r5");
        wait_led("g2r6_led", 5'b00100, 2);
        push_exp(1'b0);
        press(5'b10000);
        expect_pulse("g2_miss2");
        pause_ticks("g2r6");
        wait_led("g2r7_led", 5'b00100, 2);
        push_exp(1'b0);
        press(5'b01000);
        expect_pulse("g2_miss3");
        check("g2_over", {game_over, playing, led, lives}, {1'b1, 1'b0, 5'b0, 2'd0});
        check("g2_score_kept", score, 4);

        // Game 3: one hit, then reset mid-SHOW
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_score = 0;
        m_lives = 3;
        wait_led("g3r1_led", 5'b00100, 2);
        push_exp(1'b1);
        press(5'b00100);
        expect_pulse("g3r1");
        pause_ticks("g3r1");
        wait_led("g3r2_led", 5'b00100, 2);
        reset = 1'b1;
        #1;
        check("midrst_led", led, 0);
        check("midrst_score", score, 0);
        check("midrst_lives", lives, 3);
        check("midrst_flags", {playing, hit_pulse, miss_pulse, game_over}, 0);
        check("midrst_score2", score2, 0);
        cyc();
        reset = 1'b0;
        begin
            int active = 0;
            for (int i = 0; i < 6; i++) begin
                cyc();
                if (playing || led != 5'b0 || hit_pulse || miss_pulse || game_over) active++;
            end
            check("idle_after_rst", active, 0);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("idle_start", playing, 1);
        check("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
